cpu_muldiv_seq: RTL
===================

Name: cpu_muldiv_seq

Overview:
Iterative multiply/divide sequencer beside the execute-stage ALU. It accepts a multi-cycle arithmetic op issued from stage 2a and stalls the front of the pipeline while it iterates. It then presents a one-cycle result for the execute stage to latch into its 3a output register in place of the ALU result. A kill from stage 4a aborts an in-flight operation.

Parameters:
XLEN, 32, operand/result width (counter width = clog2(XLEN)+1)

Ports:
clk  input  1  clock
rst_b  input  1  synchronous active-low reset
md__req_2a  input  1  multi-cycle op present in stage 2a (decoded)
md__op_2a  input  2  00 MULLO, 01 MULHU, 10 DIVU, 11 REMU
md__left_2a  input  XLEN  operand A (selected ALU-left value: multiplicand/dividend)
md__right_2a  input  XLEN  operand B (selected ALU-right value: multiplier/divisor)
kill_4a  input  1  flush; abort any in-flight op
md__stall_2a  output  1  hold stages 0a-2a this cycle
md__valid  output  1  result valid this cycle (one-cycle pulse)
md__out  output  XLEN  result
md__busy  output  1  state != IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-low (rst_b sampled on posedge clk). Reset forces state=IDLE, count=0, acc/quotient registers=0, md__out=0, md__valid=0. md__stall_2a and md__busy are therefore 0 after reset.
- Reset mid-operation discards all work; no md__valid is produced.
- State IDLE:
  - md__stall_2a = md__req_2a & ~kill_4a (combinational).
  - On md__req_2a & ~kill_4a: latch op and operands, set count=XLEN.
  - If op is DIVU/REMU and md__right_2a==0, go to DONE. DIVU result = all-ones; REMU result = dividend.
  - Otherwise go to RUN.
- State RUN:
  - md__stall_2a=1. One iteration per cycle; count decrements each cycle.
  - When count reaches 1 in RUN, the next state is DONE.
  - Multiply: 2*XLEN product register {hi,lo}; lo is initialised to the multiplier. Each cycle, hi' = hi + (lo[0] ? multiplicand : 0) with carry, then the {carry,hi,lo} register shifts right 1.
  - MULLO returns lo; MULHU returns hi. Both are unsigned; MULLO is also correct for signed operands.
  - Divide: restoring, unsigned. rem_shift = {rem, quot[XLEN-1]}. If rem_shift >= divisor, rem = rem_shift - divisor and shift 1 into quot; else rem = rem_shift and shift 0 into quot.
  - DIVU returns quot; REMU returns rem.
- State DONE:
  - md__valid=1, md__stall_2a=0, md__out=result. The pipeline advances the same instruction into 3a this cycle.
  - md__req_2a in DONE belongs to that same instruction and is ignored.
  - Next state is always IDLE.
- Latency: request accepted in IDLE cycle N gives RUN in N+1..N+XLEN and md__valid in N+XLEN+1. Divide by zero gives md__valid in N+1.
- Throughput: back-to-back ops need one IDLE cycle between them (minimum XLEN+2 cycles per op).
- md__out holds its last value outside DONE; consumers must qualify it with md__valid.
- kill_4a:
  - In IDLE, kill_4a blocks acceptance.
  - In RUN or DONE, kill_4a forces IDLE next cycle.
  - md__valid is still asserted in a DONE cycle that coincides with kill_4a; the downstream kill handles that instruction.
  - md__stall_2a in RUN drops the cycle after kill_4a.
- Simultaneous kill_4a and md__req_2a in IDLE: kill_4a wins, and the request is not accepted.
- Arithmetic is modulo 2^XLEN; no overflow flags.

Test Plan:
- Reset then MULLO 7*6: req in cycle 0 -> md__stall_2a=1 cycles 0..32, md__valid=1 in cycle 33 with md__out=42, md__busy=0 in cycle 34.
- MULHU 0xFFFFFFFF*0xFFFFFFFF -> md__out=0xFFFFFFFE. MULLO of the same operands -> md__out=0x00000001.
- DIVU 100/7 -> md__out=14; REMU 100/7 -> 2. DIVU 0x80000000/1 -> 0x80000000.
- Divide by zero: DIVU 5/0 -> md__valid in cycle 1 with md__out=0xFFFFFFFF; REMU 5/0 -> md__out=5.
- kill_4a in RUN cycle 10 -> IDLE in cycle 11, md__valid never asserted, md__stall_2a=0 from cycle 11. req+kill in the same IDLE cycle -> no acceptance, md__busy stays 0.
- rst_b=0 in RUN cycle 5 -> all outputs 0 next cycle. A following op 3*3 completes normally with md__out=9.

Source files
------------

// File: rtl/cpu_muldiv_seq.sv
// cpu_muldiv_seq: iterative multiply/divide sequencer beside the execute-stage ALU.
// Accepts a multi-cycle op in stage 2a, stalls stages 0a-2a while iterating one
// bit per cycle, then presents a one-cycle result pulse for the 3a register.
//
// state | meaning
// IDLE  | waiting for md__req_2a; stall follows the request combinationally
// RUN   | one shift-add / restoring-subtract step per cycle, count down to 1
// DONE  | md__valid pulse with result; always returns to IDLE
//
// Ports:
//   clk, rst_b        clock, synchronous active-low reset
//   md__req_2a        multi-cycle op present in stage 2a
//   md__op_2a         00 MULLO, 01 MULHU, 10 DIVU, 11 REMU
//   md__left_2a       multiplicand / dividend
//   md__right_2a      multiplier / divisor
//   kill_4a           abort any in-flight op
//   md__stall_2a      hold stages 0a-2a
//   md__valid         one-cycle result strobe
//   md__out           result (holds last value outside DONE)
//   md__busy          sequencer not idle
module cpu_muldiv_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_b,
  input  logic            md__req_2a,
  input  logic [1:0]      md__op_2a,
  input  logic [XLEN-1:0] md__left_2a,
  input  logic [XLEN-1:0] md__right_2a,
  input  logic            kill_4a,
  output logic            md__stall_2a,
  output logic            md__valid,
  output logic [XLEN-1:0] md__out,
  output logic            md__busy
);

  localparam int CW = $clog2(XLEN) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [1:0]      op_q, op_d;
  logic [XLEN-1:0] b_q, b_d;     // multiplicand or divisor
  logic [XLEN-1:0] hi_q, hi_d;   // product high half or partial remainder
  logic [XLEN-1:0] lo_q, lo_d;   // multiplier/product low half or dividend/quotient
  logic [XLEN-1:0] out_q, out_d;

  logic            accept;
  logic [XLEN:0]   mul_sum;
  logic [XLEN-1:0] mul_hi_n, mul_lo_n;
  logic [XLEN:0]   rem_shift, rem_sub;
  logic            rem_ge;
  logic [XLEN-1:0] div_hi_n, div_lo_n;

  assign accept = md__req_2a & ~kill_4a;

  // Shift-add step: carry out of the add lands in the top bit of hi after the shift.
  assign mul_sum  = {1'b0, hi_q} + {1'b0, (lo_q[0] ? b_q : '0)};
  assign mul_hi_n = mul_sum[XLEN:1];
  assign mul_lo_n = {mul_sum[0], lo_q[XLEN-1:1]};

  // Restoring divide step: dividend bits enter the remainder from the top of lo,
  // quotient bits fill lo from the bottom.
  assign rem_shift = {hi_q, lo_q[XLEN-1]};
  assign rem_sub   = rem_shift - {1'b0, b_q};
  assign rem_ge    = (rem_shift >= {1'b0, b_q});
  assign div_hi_n  = rem_ge ? rem_sub[XLEN-1:0] : rem_shift[XLEN-1:0];
  assign div_lo_n  = {lo_q[XLEN-2:0], rem_ge};

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    op_d    = op_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    out_d   = out_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d    = md__op_2a;
          count_d = CW'(XLEN);
          hi_d    = '0;
          if (md__op_2a[1]) begin
            b_d  = md__right_2a;
            lo_d = md__left_2a;
          end else begin
            b_d  = md__left_2a;
            lo_d = md__right_2a;
          end
          if (md__op_2a[1] && (md__right_2a == '0)) begin
            state_d = S_DONE;
            out_d   = md__op_2a[0] ? md__left_2a : '1;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (kill_4a) begin
          state_d = S_IDLE;
        end else begin
          count_d = count_q - CW'(1);
          hi_d    = op_q[1] ? div_hi_n : mul_hi_n;
          lo_d    = op_q[1] ? div_lo_n : mul_lo_n;
          if (count_q == CW'(1)) begin
            state_d = S_DONE;
            case (op_q)
              2'b00:   out_d = mul_lo_n;
              2'b01:   out_d = mul_hi_n;
              2'b10:   out_d = div_lo_n;
              default: out_d = div_hi_n;
            endcase
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q <= S_IDLE;
      count_q <= '0;
      op_q    <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      op_q    <= op_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      out_q   <= out_d;
    end
  end

  assign md__valid    = (state_q == S_DONE);
  assign md__busy     = (state_q != S_IDLE);
  assign md__stall_2a = (state_q == S_RUN) | ((state_q == S_IDLE) & accept);
  assign md__out      = out_q;

endmodule
